// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller for the S&H / auto-zero comparator / R-2R DAC macro set.
// Ports: clk, rst_n (async, active-low); start, continuous, abort, result_ack (control);
//        comp_in (asynchronous comparator output); sh_sample, comp_cal, comp_en_n, dac_code (analog drive);
//        result, result_valid, result_pending, overrun, busy (status and result handshake).
module sar_adc_ctrl #(
   parameter int N_BITS        = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int SYNC_STAGES   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic              comp_in,
   input  logic              result_ack,
   output logic              sh_sample,
   output logic              comp_cal,
   output logic              comp_en_n,
   output logic [N_BITS-1:0] dac_code,
   output logic [N_BITS-1:0] result,
   output logic              result_valid,
   output logic              result_pending,
   output logic              overrun,
   output logic              busy
);
   localparam int K  = SETTLE_CYCLES + SYNC_STAGES + 1;
   localparam int IW = $clog2(N_BITS);
   typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, DECIDE, DONE} state_t;
   state_t                 state, nxt;
   logic [15:0]            cnt;
   logic [IW-1:0]          idx;
   logic [SYNC_STAGES-1:0] sync;
   logic                   comp_s;
   assign comp_s         = sync[SYNC_STAGES-1];
   assign busy           = state != IDLE;
   assign sh_sample      = state == SAMPLE;
   assign comp_cal       = state == SAMPLE;
   assign comp_en_n      = !(state == TRIAL || state == DECIDE);
   // abort overrides completion, so a DONE cycle that is aborted never reports
   assign result_valid   = state == DONE && !abort;
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = start ? SAMPLE : IDLE;
         SAMPLE:  nxt = cnt == 16'(SAMPLE_CYCLES - 1) ? TRIAL : SAMPLE;
         TRIAL:   nxt = cnt == 16'(K - 2) ? DECIDE : TRIAL;
         DECIDE:  nxt = idx == '0 ? DONE : TRIAL;
         DONE:    nxt = continuous ? SAMPLE : IDLE;
         default: nxt = IDLE;
      endcase
      if (abort && state != IDLE) nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         idx            <= '0;
         sync           <= '0;
         dac_code       <= '0;
         result         <= '0;
         result_pending <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         state <= nxt;
         sync  <= {sync[SYNC_STAGES-2:0], comp_in};
         cnt   <= nxt != state ? '0 : cnt + 16'd1;
         if (nxt == IDLE || nxt == SAMPLE) begin
            dac_code <= '0;
         end else if (state == SAMPLE && nxt == TRIAL) begin
            idx      <= IW'(N_BITS - 1);
            dac_code <= {1'b1, {(N_BITS-1){1'b0}}};
         end else if (state == DECIDE) begin
            // resolve this bit and raise the next trial bit on the same edge
            dac_code[idx] <= comp_s;
            if (idx != '0) begin
               dac_code[idx - 1'b1] <= 1'b1;
               idx                  <= idx - 1'b1;
            end
         end
         if (result_valid) result <= dac_code;
         result_pending <= result_valid ? 1'b1 : result_ack ? 1'b0 : result_pending;
         overrun        <= result_ack ? 1'b0 : (result_valid && result_pending) ? 1'b1 : overrun;
      end
   end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed self-checking bench for sar_adc_ctrl (default and 10-bit instances).
module tb_sar_adc_ctrl;
   logic clk = 0, rst_n = 0;
   logic start = 0, continuous = 0, abort = 0, result_ack = 0;
   logic [7:0] vin = 0;
   logic sh_sample, comp_cal, comp_en_n, result_valid, result_pending, overrun, busy;
   logic [7:0] dac_code, result;
   logic comp_in;
   assign comp_in = vin >= dac_code;
   logic start10 = 0, zero10 = 0;
   logic [9:0] vin10 = 10'h2AB;
   logic sh10, cal10, en10_n, rv10, pend10, ovr10, busy10, comp10;
   logic [9:0] dac10, res10;
   assign comp10 = vin10 >= dac10;
   int vec = 0, err = 0, cyc = 0;
   logic [7:0] trace[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   sar_adc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
      .comp_in(comp_in), .result_ack(result_ack), .sh_sample(sh_sample), .comp_cal(comp_cal),
      .comp_en_n(comp_en_n), .dac_code(dac_code), .result(result), .result_valid(result_valid),
      .result_pending(result_pending), .overrun(overrun), .busy(busy));
   sar_adc_ctrl #(.N_BITS(10), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start10), .continuous(zero10), .abort(zero10),
      .comp_in(comp10), .result_ack(zero10), .sh_sample(sh10), .comp_cal(cal10),
      .comp_en_n(en10_n), .dac_code(dac10), .result(res10), .result_valid(rv10),
      .result_pending(pend10), .overrun(ovr10), .busy(busy10));
   // pulse start for one edge, then count cycles until result_valid, logging trial codes
   task automatic convert(input logic [7:0] v, output int lat);
      vin = v;
      trace.delete();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      lat = 1;
      while (!result_valid && lat < 100) begin
         if (!comp_en_n && (trace.size() == 0 || trace[$] !== dac_code)) trace.push_back(dac_code);
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic ack_once;
      @(negedge clk) result_ack = 1;
      @(negedge clk) result_ack = 0;
   endtask
   task automatic test_reset;
      #1;
      vec++;
      if ({sh_sample, comp_cal, comp_en_n, dac_code, result, result_valid, result_pending, overrun, busy} !== {3'b001, 16'h0, 4'h0}) begin
         err++;
         $display("FAIL reset_async: got sh=%b cal=%b en_n=%b dac=%h res=%h rv=%b pend=%b ovr=%b busy=%b", sh_sample, comp_cal, comp_en_n, dac_code, result, result_valid, result_pending, overrun, busy);
      end
      @(negedge clk) rst_n = 1;
      @(negedge clk);
      vec++;
      if ({sh_sample, comp_en_n, dac_code, busy, result_valid} !== {2'b01, 8'h0, 2'b00}) begin
         err++;
         $display("FAIL reset_idle: got sh=%b en_n=%b dac=%h busy=%b rv=%b, want 0 1 00 0 0", sh_sample, comp_en_n, dac_code, busy, result_valid);
      end
   endtask
   task automatic test_basic;
      int lat;
      convert(8'hA5, lat);
      vec++;
      if (lat !== 37) begin err++; $display("FAIL basic_latency: got %0d want 37", lat); end
      @(negedge clk);
      vec++;
      if (result !== 8'hA5) begin err++; $display("FAIL basic_result: got %h want a5", result); end
      vec++;
      if ({busy, result_valid, result_pending} !== 3'b001) begin err++; $display("FAIL basic_status: got busy=%b rv=%b pend=%b want 0 0 1", busy, result_valid, result_pending); end
      ack_once();
      vec++;
      if (result_pending !== 1'b0) begin err++; $display("FAIL basic_ack: got pend=%b want 0", result_pending); end
   endtask
   task automatic test_extremes;
      int lat;
      logic [7:0] e;
      bit bad;
      for (int t = 0; t < 2; t++) begin
         convert(t == 0 ? 8'h00 : 8'hFF, lat);
         @(negedge clk);
         vec++;
         if (result !== (t == 0 ? 8'h00 : 8'hFF)) begin err++; $display("FAIL extreme_result%0d: got %h want %h", t, result, t == 0 ? 8'h00 : 8'hFF); end
         bad = trace.size() != 8;
         for (int k = 0; k < 8 && !bad; k++) begin
            e = t == 0 ? 8'h80 >> k : 8'hFF << (7 - k);
            if (trace[k] !== e) bad = 1;
         end
         vec++;
         if (bad) begin err++; $display("FAIL extreme_trace%0d: got %0d codes, first %h, want 8 codes from 80", t, trace.size(), trace.size() ? trace[0] : 8'hxx); end
         ack_once();
      end
   endtask
   task automatic test_continuous;
      logic [7:0] vals [3] = '{8'h10, 8'h7F, 8'hE0};
      int lat, t0;
      continuous = 1;
      convert(vals[0], lat);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            lat = 0;
            while (!result_valid && lat < 100) begin @(negedge clk); lat++; end
            vec++;
            if (cyc - t0 !== 37) begin err++; $display("FAIL cont_period%0d: got %0d want 37", k, cyc - t0); end
         end
         t0 = cyc;
         if (k < 2) vin = vals[k+1];
         @(negedge clk) result_ack = 1;
         vec++;
         if (result !== vals[k]) begin err++; $display("FAIL cont_result%0d: got %h want %h", k, result, vals[k]); end
         @(negedge clk) result_ack = 0;
         vec++;
         if (overrun !== 1'b0) begin err++; $display("FAIL cont_overrun%0d: got %b want 0", k, overrun); end
      end
      continuous = 0;
      @(negedge clk) abort = 1;
      @(negedge clk) abort = 0;
   endtask
   task automatic test_overrun;
      int lat;
      continuous = 1;
      convert(8'h33, lat);
      lat = 0;
      @(negedge clk);
      while (!result_valid && lat < 100) begin @(negedge clk); lat++; end
      continuous = 0;
      @(negedge clk);
      vec++;
      if ({overrun, result_pending} !== 2'b11) begin err++; $display("FAIL overrun_set: got ovr=%b pend=%b want 1 1", overrun, result_pending); end
      abort = 1;
      result_ack = 1;
      @(negedge clk) abort = 0;
      result_ack = 0;
      vec++;
      if ({overrun, result_pending, busy} !== 3'b000) begin err++; $display("FAIL overrun_clear: got ovr=%b pend=%b busy=%b want 0 0 0", overrun, result_pending, busy); end
   endtask
   task automatic test_abort;
      int lat;
      bit seen = 0;
      vin = 8'hA5;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      for (int c = 2; c <= 7; c++) @(negedge clk) seen |= result_valid;
      abort = 1;
      @(negedge clk) abort = 0;
      vec++;
      if ({busy, dac_code, comp_en_n, seen, result} !== {1'b0, 8'h00, 1'b1, 1'b0, 8'h33}) begin
         err++;
         $display("FAIL abort_idle: got busy=%b dac=%h en_n=%b rv_seen=%b res=%h want 0 00 1 0 33", busy, dac_code, comp_en_n, seen, result);
      end
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      lat = 1;
      while (!result_valid && lat < 100) begin
         if (lat == 10) start = 1;
         if (lat == 11) start = 0;
         @(negedge clk);
         lat++;
      end
      vec++;
      if (lat !== 37) begin err++; $display("FAIL start_ignored: got latency %0d want 37", lat); end
      ack_once();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      repeat (10) @(negedge clk);
      rst_n = 0;
      #1;
      vec++;
      if ({sh_sample, comp_cal, comp_en_n, dac_code, result, result_valid, result_pending, overrun, busy} !== {3'b001, 16'h0, 4'h0}) begin
         err++;
         $display("FAIL reset_midconv: got en_n=%b dac=%h res=%h busy=%b", comp_en_n, dac_code, result, busy);
      end
      @(negedge clk) rst_n = 1;
   endtask
   task automatic test_wide;
      int lat;
      @(negedge clk) start10 = 1;
      @(negedge clk) start10 = 0;
      lat = 1;
      while (!rv10 && lat < 200) begin @(negedge clk); lat++; end
      vec++;
      if (lat !== 63) begin err++; $display("FAIL wide_latency: got %0d want 63", lat); end
      @(negedge clk);
      vec++;
      if (res10 !== 10'h2AB) begin err++; $display("FAIL wide_result: got %h want 2ab", res10); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_continuous();
      test_overrun();
      test_abort();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Parametrised successive-approximation controller for the SAR ADC analog macro set: sample-and-hold, auto-zeroing comparator, R-2R DAC. It replaces manual drive of the DAC bits from `ui_in` with on-chip binary search. It sequences S&H sampling, comparator calibration/enable, DAC trial codes and result capture. It supports single-shot and continuous modes, configurable resolution and timing, and result handshake with overrun detection.

Parameters:
- `N_BITS`, 8, conversion resolution; width of `dac_code` and `result`.
- `SAMPLE_CYCLES`, 4, cycles `sh_sample` is held high per conversion (>=1).
- `SETTLE_CYCLES`, 1, DAC/comparator settle cycles per bit trial (>=0).
- `SYNC_STAGES`, 2, flops in the `comp_in` synchronizer (>=2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin conversion; sampled only in IDLE.
- `continuous`  in  1  when 1, restart automatically after each result.
- `abort`  in  1  terminate any conversion, return to IDLE.
- `comp_in`  in  1  comparator output, asynchronous; 1 = held input >= DAC level.
- `result_ack`  in  1  consumer acknowledges `result`.
- `sh_sample`  out  1  S&H clock; 1 = track, 0 = hold.
- `comp_cal`  out  1  comparator auto-zero.
- `comp_en_n`  out  1  comparator enable, active-low.
- `dac_code`  out  `N_BITS`  R-2R DAC bit drive.
- `result`  out  `N_BITS`  last completed code; held until the next completion.
- `result_valid`  out  1  one-cycle pulse on completion.
- `result_pending`  out  1  result not yet acknowledged.
- `overrun`  out  1  sticky; a result completed while the previous one was still pending.
- `busy`  out  1  state != IDLE.

Behaviour:
- **Reset (`rst_n`=0, async):**
  - state IDLE.
  - `dac_code`=0, `result`=0, `sh_sample`=0, `comp_cal`=0, `comp_en_n`=1.
  - `result_valid`=0, `result_pending`=0, `overrun`=0, `busy`=0.
  - synchronizer flops=0.
- **`comp_in` synchronizer:** passes through `SYNC_STAGES` flops before use.
- **Bit phase:** K = `SETTLE_CYCLES` + `SYNC_STAGES` + 1.
- **IDLE:**
  - Outputs at idle values.
  - `start`=1 at cycle T moves to SAMPLE at T+1.
- **SAMPLE:**
  - Lasts `SAMPLE_CYCLES` cycles; `sh_sample`=1, `comp_cal`=1, `dac_code`=0.
  - Then TRIAL for bit `N_BITS`-1.
- **TRIAL(i):**
  - First cycle sets `dac_code[i]`=1, keeping decided higher bits and leaving lower bits 0.
  - `sh_sample`=0, `comp_cal`=0, `comp_en_n`=0.
  - Holds K-1 cycles, then DECIDE(i).
- **DECIDE(i):** one cycle.
  - Synchronized comp=0 clears `dac_code[i]`; comp=1 keeps it.
  - i>0: go to TRIAL(i-1). i=0: go to DONE.
- **DONE:** one cycle.
  - `result` <= final code; `result_valid`=1; `comp_en_n`=1.
  - Next state SAMPLE if `continuous`=1, else IDLE.
  - In both cases `dac_code` is 0 from the next cycle.
- **Latency:**
  - `result_valid` asserts at T + L, where L = `SAMPLE_CYCLES` + `N_BITS`*K + 1 (defaults: 37).
  - Continuous-mode result period is L.
- **`start` while busy:** ignored.
- **`continuous` changes mid-conversion:** take effect at DONE only.
- **`abort`:**
  - Highest priority in any non-IDLE state: next cycle IDLE with idle output values.
  - No `result_valid`; `result`, `result_pending` and `overrun` unchanged.
- **`result_pending`:** set on `result_valid`; cleared when `result_ack`=1.
- **`result_valid` and `result_ack` in the same cycle:**
  - If `result_pending` was 1: pending stays 1 and `overrun` is not set (the old result is acked, the new one is pending).
- **`overrun`:**
  - Set when `result_valid`=1, `result_pending`=1 and `result_ack`=0.
  - Cleared by `result_ack` or reset.
- **`result_ack` with nothing pending:** no effect.

Test Plan:
1. Comparator model comp_in=(vin >= dac_code), vin=0xA5, defaults, single start pulse -> `result_valid` exactly 37 cycles after start; `result`=0xA5; `busy` falls the cycle after DONE.
2. vin=0x00 and vin=0xFF -> `result`=0x00 and 0xFF; verify trial sequence 0x80,0x40,... for 0x00 and 0x80,0xC0,... for 0xFF.
3. `continuous`=1, vin stepping 0x10, 0x7F, 0xE0 between conversions, ack each result -> three `result_valid` pulses 37 cycles apart with matching codes; `overrun` stays 0.
4. Continuous mode, no ack -> second `result_valid` sets `overrun`=1; next `result_ack` clears both `overrun` and `result_pending`.
5. `abort` asserted on the 3rd TRIAL cycle -> IDLE next cycle; `dac_code`=0; `comp_en_n`=1; no `result_valid`; previous `result` retained. Also: `start` pulsed mid-conversion is ignored. Also: `rst_n` low mid-conversion clears all outputs immediately.
6. `N_BITS`=10, `SAMPLE_CYCLES`=2, `SETTLE_CYCLES`=3 -> L=2+10*6+1=63; vin=0x2AB gives `result`=0x2AB.
